hack_fetch_unit: RTL and testbench
==================================

Name: hack_fetch_unit

Overview:
- Instruction-fetch consumer of the 16-bit program counter.
- Takes the current PC value, issues a read to instruction ROM over a valid/ready request channel, and captures the response.
- Presents the instruction to the CPU over a valid/ready channel.
- Returns a one-cycle increment pulse to the PC when the CPU accepts the instruction.
- A flush input discards in-flight work when the PC is loaded or reset.

Parameters:
- ADDR_W, 16, width of the PC, ROM address and instr_addr.
- DATA_W, 16, instruction width.
- TIMEOUT, 8, maximum cycles in WAIT or DRAIN before abandoning a ROM response (≥2).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- pc  in  ADDR_W  current program counter value.
- pc_inc  out  1  combinational increment pulse to the PC.
- flush  in  1  PC is being loaded or reset this cycle; discard current fetch.
- rom_req_valid  out  1  ROM read request valid.
- rom_req_ready  in  1  ROM accepts request.
- rom_addr  out  ADDR_W  ROM read address.
- rom_rsp_valid  in  1  ROM read data valid; single-cycle, in-order.
- rom_rsp_data  in  DATA_W  ROM read data.
- instr_valid  out  1  instruction available to CPU.
- instr_ready  in  1  CPU accepts instruction.
- instr  out  DATA_W  fetched instruction.
- instr_addr  out  ADDR_W  address instr was fetched from.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- reset==0 at a rising edge:
  - state=SETTLE; timeout counter=0; fetch_err=0.
  - instr, instr_addr, rom_addr=0.
  - rom_req_valid, instr_valid, pc_inc=0.
  - Any pending ROM response is ignored.
- States: SETTLE, REQ, WAIT, HOLD, DRAIN.
- SETTLE:
  - All handshake outputs low.
  - If flush=0: rom_addr<=pc, next REQ.
  - If flush=1: stay in SETTLE.
- REQ:
  - rom_req_valid=1; rom_addr held stable.
  - rom_req_ready=1: counter<=0, next WAIT.
  - flush=1 with no handshake: request withdrawn, next SETTLE. This is the only legal withdrawal of rom_req_valid.
  - flush=1 with handshake in the same cycle: next DRAIN.
- WAIT:
  - rom_rsp_valid=1 and flush=0: instr<=rom_rsp_data, instr_addr<=rom_addr, next HOLD.
  - rom_rsp_valid=1 and flush=1: data discarded, next SETTLE.
  - flush=1 without response: next DRAIN.
  - Otherwise the counter increments. When it reaches TIMEOUT-1: fetch_err<=1, next SETTLE; fetch is retried at the current pc.
- HOLD:
  - instr_valid=1; instr and instr_addr stable until accepted.
  - pc_inc = instr_valid & instr_ready & ~flush (combinational); the PC advances on the same edge.
  - Accept: next SETTLE.
  - flush=1: instr_valid drops, no pc_inc, next SETTLE.
- DRAIN:
  - Waits for the one outstanding response and discards it, then next SETTLE.
  - Same timeout rule as WAIT (sets fetch_err, then SETTLE).
  - flush during DRAIN has no further effect.
- rom_rsp_valid outside WAIT/DRAIN is ignored.
- SETTLE guarantees rom_addr samples the PC after its increment or load edge.
- Minimum cycle per instruction is 4 (SETTLE, REQ, WAIT, HOLD) with zero-wait ROM and CPU. With an already-ready CPU, HOLD lasts exactly 1 cycle.
- At most one ROM request is outstanding; rom_req_valid never asserts while a response is owed.
- Address arithmetic is performed by the PC, not this block; PC wrap 0xFFFF→0x0000 is fetched like any other address.
- fetch_err stays set until reset.

Test Plan:
- Basic fetch: reset low 1 cycle, pc=0x0000, ROM ready always, rsp next cycle with data 0xEA10, CPU ready always → rom_addr=0x0000; instr=0xEA10 with instr_addr=0x0000 and instr_valid for 1 cycle; pc_inc pulses once; next rom_addr=0x0001; 4 cycles per instruction.
- Backpressure: instr_ready low for 5 cycles while in HOLD → instr_valid held high, instr stable, pc_inc stays 0 until ready rises, then pulses exactly once.
- ROM stall: rom_req_ready low 3 cycles → rom_req_valid high with rom_addr stable, no response accepted before the handshake; rsp delayed 4 cycles → captured correctly.
- Jump flush during WAIT: flush=1 with pc loaded to 0x0100 → old response discarded in DRAIN, no instr_valid for it; next rom_addr=0x0100.
- Timeout: no rom_rsp_valid for TIMEOUT cycles → fetch_err=1 sticky, fetch retried at the same pc; later normal response delivered; fetch_err cleared only by reset.
- Reset mid-operation: reset low while in HOLD with 0x1234 presented → instr_valid=0, instr=0, fetch_err=0 next cycle; a stale rom_rsp_valid after reset is ignored.

Source files
------------

// File: rtl/hack_fetch_unit.sv
// Instruction fetch stage for the Hack CPU: samples the PC, reads instruction ROM
// over a valid/ready channel and hands the instruction to the CPU, pulsing pc_inc on accept.
module hack_fetch_unit #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_inc,
   input  logic              flush,
   output logic              rom_req_valid,
   input  logic              rom_req_ready,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic              rom_rsp_valid,
   input  logic [DATA_W-1:0] rom_rsp_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              fetch_err
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {SETTLE, REQ, WAIT, HOLD, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fetch_err_q, fetch_err_d;
   logic              rom_req_valid_q, rom_req_valid_d;
   logic              instr_valid_q, instr_valid_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
   logic [DATA_W-1:0] instr_q, instr_d;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      fetch_err_d     = fetch_err_q;
      rom_req_valid_d = rom_req_valid_q;
      instr_valid_d   = instr_valid_q;
      rom_addr_d      = rom_addr_q;
      instr_addr_d    = instr_addr_q;
      instr_d         = instr_q;

      case (state_q)
         // SETTLE gives the PC one edge to increment or load before it is sampled
         SETTLE: begin
            if (!flush) begin
               rom_addr_d      = pc;
               rom_req_valid_d = 1'b1;
               state_d         = REQ;
            end
         end
         REQ: begin
            if (rom_req_ready) begin
               cnt_d           = '0;
               rom_req_valid_d = 1'b0;
               state_d         = flush ? DRAIN : WAIT;
            end else if (flush) begin
               rom_req_valid_d = 1'b0;
               state_d         = SETTLE;
            end
         end
         WAIT: begin
            if (rom_rsp_valid) begin
               if (!flush) begin
                  instr_d       = rom_rsp_data;
                  instr_addr_d  = rom_addr_q;
                  instr_valid_d = 1'b1;
                  state_d       = HOLD;
               end else begin
                  state_d = SETTLE;
               end
            end else if (flush) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else if (cnt_q == CNT_MAX) begin
               fetch_err_d = 1'b1;
               state_d     = SETTLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (flush || instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = SETTLE;
            end
         end
         // A response is still owed; swallow it so it cannot be mistaken for a new fetch
         DRAIN: begin
            if (rom_rsp_valid) begin
               state_d = SETTLE;
            end else if (cnt_q == CNT_MAX) begin
               fetch_err_d = 1'b1;
               state_d     = SETTLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            rom_req_valid_d = 1'b0;
            instr_valid_d   = 1'b0;
            state_d         = SETTLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= SETTLE;
         cnt_q           <= '0;
         fetch_err_q     <= 1'b0;
         rom_req_valid_q <= 1'b0;
         instr_valid_q   <= 1'b0;
         rom_addr_q      <= '0;
         instr_addr_q    <= '0;
         instr_q         <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         fetch_err_q     <= fetch_err_d;
         rom_req_valid_q <= rom_req_valid_d;
         instr_valid_q   <= instr_valid_d;
         rom_addr_q      <= rom_addr_d;
         instr_addr_q    <= instr_addr_d;
         instr_q         <= instr_d;
      end
   end

   assign pc_inc        = instr_valid_q & instr_ready & ~flush;
   assign rom_req_valid = rom_req_valid_q;
   assign rom_addr      = rom_addr_q;
   assign instr_valid   = instr_valid_q;
   assign instr         = instr_q;
   assign instr_addr    = instr_addr_q;
   assign fetch_err     = fetch_err_q;

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Directed bench for hack_fetch_unit: a small PC model plus hand-driven ROM and CPU
// handshakes, with every expected value written out by hand.
module tb_hack_fetch_unit;

   logic        clk;
   logic        reset;
   logic [15:0] pc;
   logic        pc_inc;
   logic        flush;
   logic        rom_req_valid;
   logic        rom_req_ready;
   logic [15:0] rom_addr;
   logic        rom_rsp_valid;
   logic [15:0] rom_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] instr_addr;
   logic        fetch_err;
   logic [15:0] pcLoadVal;

   int checkCount;
   int passCount;

   hack_fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .pc            (pc),
      .pc_inc        (pc_inc),
      .flush         (flush),
      .rom_req_valid (rom_req_valid),
      .rom_req_ready (rom_req_ready),
      .rom_addr      (rom_addr),
      .rom_rsp_valid (rom_rsp_valid),
      .rom_rsp_data  (rom_rsp_data),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_addr    (instr_addr),
      .fetch_err     (fetch_err)
   );

   always #5 clk = ~clk;

   // The PC itself: cleared by reset, loaded alongside flush, advanced by pc_inc
   always @(posedge clk) begin
      if (!reset)
         pc <= 16'h0000;
      else if (flush)
         pc <= pcLoadVal;
      else if (pc_inc)
         pc <= pc + 16'h0001;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
   endtask

   task automatic applyStimulus(input logic rr, input logic rv, input logic [15:0] rd,
                                input logic ir, input logic fl, input logic [15:0] lv);
      rom_req_ready = rr;
      rom_rsp_valid = rv;
      rom_rsp_data  = rd;
      instr_ready   = ir;
      flush         = fl;
      pcLoadVal     = lv;
      #1;
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      clk        = 1'b0;
      reset      = 1'b0;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      waitCycle();
      checkOutput("reset_instr_valid", instr_valid, 0);
      checkOutput("reset_req_valid", rom_req_valid, 0);
      checkOutput("reset_fetch_err", fetch_err, 0);
      checkOutput("reset_instr", instr, 0);
      checkOutput("reset_instr_addr", instr_addr, 0);
      checkOutput("reset_rom_addr", rom_addr, 0);
      reset = 1'b1;

      // basic fetch with zero-wait ROM and an always-ready CPU
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("basic_req_valid", rom_req_valid, 1);
      checkOutput("basic_rom_addr0", rom_addr, 16'h0000);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("basic_req_dropped", rom_req_valid, 0);
      checkOutput("basic_no_instr_yet", instr_valid, 0);
      applyStimulus(1'b1, 1'b1, 16'hEA10, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("basic_instr_valid", instr_valid, 1);
      checkOutput("basic_instr", instr, 16'hEA10);
      checkOutput("basic_instr_addr", instr_addr, 16'h0000);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      checkOutput("basic_pc_inc", pc_inc, 1);
      waitCycle();
      checkOutput("basic_valid_one_cycle", instr_valid, 0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      checkOutput("basic_pc_inc_once", pc_inc, 0);
      waitCycle();
      checkOutput("basic_rom_addr1", rom_addr, 16'h0001);
      checkOutput("basic_req_again", rom_req_valid, 1);

      // CPU backpressure while holding 0x1111 from address 1
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0); waitCycle();
      applyStimulus(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0); waitCycle();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
         checkOutput("bp_no_pc_inc", pc_inc, 0);
         waitCycle();
         checkOutput("bp_valid_held", instr_valid, 1);
         checkOutput("bp_instr_stable", instr, 16'h1111);
      end
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      checkOutput("bp_pc_inc", pc_inc, 1);
      waitCycle();
      checkOutput("bp_valid_drop", instr_valid, 0);

      // ROM request stall at address 2 with stray responses, then a slow response
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 16'hBAD0, 1'b1, 1'b0, 16'h0); waitCycle();
         checkOutput("stall_req_held", rom_req_valid, 1);
         checkOutput("stall_addr_stable", rom_addr, 16'h0002);
         checkOutput("stall_no_instr", instr_valid, 0);
      end
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("stall_req_done", rom_req_valid, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
         checkOutput("stall_rsp_wait", instr_valid, 0);
      end
      applyStimulus(1'b0, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("stall_instr_valid", instr_valid, 1);
      checkOutput("stall_instr", instr, 16'h2222);
      checkOutput("stall_instr_addr", instr_addr, 16'h0002);
      checkOutput("stall_no_err", fetch_err, 0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();

      // jump flush during WAIT at address 3, PC loaded to 0x0100
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("jump_rom_addr3", rom_addr, 16'h0003);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0100); waitCycle();
      checkOutput("jump_drain_no_req", rom_req_valid, 0);
      applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("jump_discarded", instr_valid, 0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("jump_rom_addr", rom_addr, 16'h0100);
      checkOutput("jump_instr_kept", instr, 16'h2222);
      checkOutput("jump_still_invalid", instr_valid, 0);

      // timeout: eight silent WAIT cycles abandon the fetch, retry hits the same pc
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      end
      checkOutput("to_not_yet", fetch_err, 0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("to_fetch_err", fetch_err, 1);
      checkOutput("to_no_req", rom_req_valid, 0);
      checkOutput("to_no_instr", instr_valid, 0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("to_retry_addr", rom_addr, 16'h0100);
      checkOutput("to_retry_req", rom_req_valid, 1);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0); waitCycle();
      applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0); waitCycle();
      checkOutput("to_instr", instr, 16'h1234);
      checkOutput("to_instr_addr", instr_addr, 16'h0100);
      checkOutput("to_err_sticky", fetch_err, 1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      checkOutput("to_hold_no_inc", pc_inc, 0);
      waitCycle();
      checkOutput("to_hold_valid", instr_valid, 1);
      checkOutput("to_err_still", fetch_err, 1);

      // reset while holding 0x1234, with a stale response hanging around
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0); waitCycle();
      checkOutput("rst_instr_valid", instr_valid, 0);
      checkOutput("rst_instr", instr, 0);
      checkOutput("rst_instr_addr", instr_addr, 0);
      checkOutput("rst_fetch_err", fetch_err, 0);
      checkOutput("rst_rom_addr", rom_addr, 0);
      checkOutput("rst_req_valid", rom_req_valid, 0);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("rst_stale_ignored", instr_valid, 0);
      checkOutput("rst_req_valid_up", rom_req_valid, 1);
      checkOutput("rst_rom_addr0", rom_addr, 16'h0000);
      applyStimulus(1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("rst_stale_in_req", instr_valid, 0);
      checkOutput("rst_req_still", rom_req_valid, 1);

      // flush together with the request handshake, then a fetch from 0xFFFF
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF); waitCycle();
      checkOutput("fl_req_drop", rom_req_valid, 0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("fl_drain_no_req", rom_req_valid, 0);
      checkOutput("fl_drain_no_instr", instr_valid, 0);
      applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("fl_discarded", instr_valid, 0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("fl_rom_addr_ffff", rom_addr, 16'hFFFF);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      applyStimulus(1'b0, 1'b1, 16'h4444, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("fl_instr", instr, 16'h4444);
      checkOutput("fl_instr_addr", instr_addr, 16'hFFFF);

      // flush while the CPU accepts: no increment, fetch restarts at the load target
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0010);
      checkOutput("fl_hold_no_inc", pc_inc, 0);
      waitCycle();
      checkOutput("fl_hold_drop", instr_valid, 0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0); waitCycle();
      checkOutput("fl_rom_addr_load", rom_addr, 16'h0010);
      checkOutput("fl_err_clear", fetch_err, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
